nco_qmixer: RTL

NCO_QMIXER -- requirements
Module: nco_qmixer

---
 rtl/nco_qmixer_pkg.sv | 13 +
 rtl/nco_qmixer_rsat.sv | 42 ++++
 rtl/nco_qmixer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/nco_qmixer_pkg.sv
// rtl/nco_qmixer_pkg.sv - shared FSM state type and default widths for the quadrature mixer
package nco_qmixer_pkg;

    localparam int DEF_ADCW = 16;
    localparam int DEF_MPR  = 17;
    localparam int DEF_OW   = 24;

    typedef enum logic {
        WAIT_NCO = 1'b0,
        RUN      = 1'b1
    } state_t;

endpackage

// File: rtl/nco_qmixer_rsat.sv
// rtl/nco_qmixer_rsat.sv - drop LSBs (round or truncate) and saturate one product; NCO_QMIXER_ROUND_EN selects rounding
module nco_qmixer_rsat #(
    parameter int PW = 33,
    parameter int OW = 24
) (
    input  logic signed [PW-1:0] prod,
    output logic signed [OW-1:0] y,
    output logic                 sat
);

    localparam int DROP = PW - 1 - OW;

`ifdef NCO_QMIXER_ROUND_EN
    localparam logic signed [PW:0] RND = (PW+1)'(1) << (DROP - 1);
`else
    localparam logic signed [PW:0] RND = '0;
`endif

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    localparam logic signed [PW:0] SMAX = {{(PW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [PW:0] SMIN = {{(PW+2-OW){1'b1}}, {(OW-1){1'b0}}};

    logic signed [PW:0] ext;
    logic signed [PW:0] shifted;

    assign ext     = {prod[PW-1], prod} + RND;
    assign shifted = ext >>> DROP;

    // Clamp the scaled value to the signed output range and flag when clamping happened
    always_comb begin
        sat = 1'b0;
        y   = shifted[OW-1:0];
        if (shifted > SMAX) begin
            sat = 1'b1;
            y   = {1'b0, {(OW-1){1'b1}}};
        end else if (shifted < SMIN) begin
            sat = 1'b1;
            y   = {1'b1, {(OW-1){1'b0}}};
        end
    end

endmodule

// File: rtl/nco_qmixer.sv
// rtl/nco_qmixer.sv - 3-stage real-to-IQ mixer against an external NCO; rounding build via NCO_QMIXER_ROUND_EN
module nco_qmixer
    import nco_qmixer_pkg::*;
#(
    parameter int ADCW = DEF_ADCW,
    parameter int MPR  = DEF_MPR,
    parameter int OW   = DEF_OW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clken,
    input  logic signed [ADCW-1:0] adc_i,
    input  logic                   adc_valid,
    input  logic signed [MPR-1:0]  nco_sin,
    input  logic signed [MPR-1:0]  nco_cos,
    input  logic                   nco_valid,
    output logic signed [OW-1:0]   i_o,
    output logic signed [OW-1:0]   q_o,
    output logic                   out_valid,
    output logic                   ovf_o,
    input  logic                   ovf_clr
);

    localparam int PW = ADCW + MPR;

    state_t state;
    logic   v1;
    logic   v2;

    logic signed [ADCW-1:0] adc_r;
    logic signed [MPR-1:0]  cos_r;
    logic signed [MPR-1:0]  sin_r;
    logic signed [PW-1:0]   prod_i;
    logic signed [PW-1:0]   prod_q;

    logic signed [OW-1:0]   i_s;
    logic signed [OW-1:0]   q_s;
    logic                   sat_i;
    logic                   sat_q;

    logic accept;
    logic flush;

    assign accept = (state == RUN) && adc_valid;
    assign flush  = (state == RUN) && !nco_valid;

    // NCO-lock FSM and per-stage valid bits; losing the NCO flushes everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_NCO;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (clken) begin
            case (state)
                WAIT_NCO: if (nco_valid)  state <= RUN;
                RUN:      if (!nco_valid) state <= WAIT_NCO;
                default:                  state <= WAIT_NCO;
            endcase
            if (flush) begin
                v1        <= 1'b0;
                v2        <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                v1        <= accept;
                v2        <= v1;
                out_valid <= v2;
            end
        end
    end

    // Stage 1: capture the accepted sample together with the NCO phase it pairs with
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_r <= '0;
            cos_r <= '0;
            sin_r <= '0;
        end else if (clken && accept) begin
            adc_r <= adc_i;
            cos_r <= nco_cos;
            sin_r <= nco_sin;
        end
    end

    // Stage 2: full-precision products; Q carries the negated sine term
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_i <= '0;
            prod_q <= '0;
        end else if (clken) begin
            prod_i <= PW'(adc_r) * PW'(cos_r);
            prod_q <= -(PW'(adc_r) * PW'(sin_r));
        end
    end

    nco_qmixer_rsat #(.PW(PW), .OW(OW)) u_rsat_i (
        .prod (prod_i),
        .y    (i_s),
        .sat  (sat_i)
    );

    nco_qmixer_rsat #(.PW(PW), .OW(OW)) u_rsat_q (
        .prod (prod_q),
        .y    (q_s),
        .sat  (sat_q)
    );

    // Stage 3: register scaled outputs only for valid samples so they hold between results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_o <= '0;
            q_o <= '0;
        end else if (clken && v2 && !flush) begin
            i_o <= i_s;
            q_o <= q_s;
        end
    end

    // Sticky overflow: a new saturation wins over a coincident clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_o <= 1'b0;
        end else if (clken) begin
            ovf_o <= (v2 && !flush && (sat_i || sat_q)) || (ovf_o && !ovf_clr);
        end
    end

endmodule
